// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and constants for the SRAM data-memory controller
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
  localparam int          SRAM_DW        = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - per-halfword wait-state counter; last flags the final held cycle
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] count,
  output logic       last
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= 4'd0;
    else if (clr)
      count <= 4'd0;
    else if (en)
      count <= count + 4'd1;
  end

  assign last = (count == LAST_CNT);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit word requests over a 16-bit async SRAM, two halfwords per word
// Optional one-entry read buffer enabled by SRAM_READ_CACHE_EN.
import arm_mem_pkg::*;

module sram_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
  parameter int          SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DW-1:0]     sram_dq_out,
  input  logic [SRAM_DW-1:0]     sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  localparam int         IW           = SRAM_ADDR_W - 1;
  localparam logic [3:0] LAST_CNT     = 4'(WAIT_CYCLES - 1);
  localparam bit         FIRST_STROBE = (LAST_CNT != 4'd0);

  state_t          state;
  logic            is_wr;
  logic [IW-1:0]   word_idx;
  logic [31:0]     wdata;
  logic [3:0]      count;
  logic            last;
  logic            hit;
  logic            next_strobe;
  logic [IW-1:0]   idx_in;

  assign idx_in      = IW'((address - BASE_ADDR) >> 2);
  // Write strobe drops on the last held cycle so the address outlives we_n.
  assign next_strobe = ((count + 4'd1) != LAST_CNT);

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state == IDLE) || last),
    .en    ((state == LO) || (state == HI)),
    .count (count),
    .last  (last)
  );

`ifdef SRAM_READ_CACHE_EN
  logic          cache_valid;
  logic [IW-1:0] cache_tag;
  logic [31:0]   cache_data;

  assign hit = cache_valid && (cache_tag == idx_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else if ((state == IDLE) && wr_en && hit) begin
      cache_data <= write_data;
    end else if ((state == HI) && last && !is_wr) begin
      cache_valid <= 1'b1;
      cache_tag   <= word_idx;
      cache_data  <= {sram_dq_in, read_data[15:0]};
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign ready = (state == DONE) || ((state == IDLE) && !wr_en && (!rd_en || hit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      is_wr       <= 1'b0;
      word_idx    <= '0;
      wdata       <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || (rd_en && !hit)) begin
            state       <= LO;
            is_wr       <= wr_en;
            word_idx    <= idx_in;
            wdata       <= write_data;
            sram_addr   <= {idx_in, 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en && FIRST_STROBE;
            sram_we_n   <= !(wr_en && FIRST_STROBE);
            sram_oe_n   <= wr_en;
          end
`ifdef SRAM_READ_CACHE_EN
          else if (rd_en) begin
            read_data <= cache_data;
          end
`endif
        end
        LO: begin
          if (last) begin
            state <= HI;
            if (!is_wr)
              read_data[15:0] <= sram_dq_in;
            sram_addr   <= {word_idx, 1'b1};
            sram_dq_out <= wdata[31:16];
            sram_dq_oe  <= is_wr && FIRST_STROBE;
            sram_we_n   <= !(is_wr && FIRST_STROBE);
          end else begin
            sram_dq_oe <= is_wr && next_strobe;
            sram_we_n  <= !(is_wr && next_strobe);
          end
        end
        HI: begin
          if (last) begin
            state <= DONE;
            if (!is_wr)
              read_data[31:16] <= sram_dq_in;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
          end else begin
            sram_dq_oe <= is_wr && next_strobe;
            sram_we_n  <= !(is_wr && next_strobe);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
